// File: rtl/bnn_cls_pkg.sv
// Shared constants, state encoding and helpers for the BNN classification result stage.
package bnn_cls_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int CLASS_BIN_W = 4;

    localparam logic [CLASS_BIN_W-1:0] CLASS_INVALID = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ENCODE  = 2'd2,
        HOLD    = 2'd3
    } cls_state_e;

    function automatic logic [NUM_CLASSES-1:0] idx_to_onehot(input logic [CLASS_BIN_W-1:0] idx);
        logic [NUM_CLASSES-1:0] oh;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

endpackage

// File: rtl/cls_argmax_step.sv
// One running-argmax update: the first beat always loads, later beats load only on a
// strictly greater score so ties resolve to the lowest class index.
module cls_argmax_step #(
    parameter int SCORE_W = 10,
    parameter int IDX_W   = bnn_cls_pkg::CLASS_BIN_W
) (
    input  logic               first_i,
    input  logic [SCORE_W-1:0] max_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [IDX_W-1:0]   k_i,
    output logic [SCORE_W-1:0] max_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        max_o = max_i;
        idx_o = idx_i;
        if (first_i || (score_i > max_i)) begin
            max_o = score_i;
            idx_o = k_i;
        end
    end

endmodule

// File: rtl/cls_result_ctrl.sv
// Final classification sequencer: streams per-class scores, tracks the argmax and
// holds the encoded winner on a valid/ready result port.
module cls_result_ctrl #(
    parameter int NUM_CLASSES = bnn_cls_pkg::NUM_CLASSES,
    parameter int SCORE_W     = 10,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   score_valid,
    output logic                   score_ready,
    input  logic [SCORE_W-1:0]     score_data,
    input  logic                   score_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_CLASSES-1:0] res_onehot,
    output logic [3:0]             res_class,
    output logic [SCORE_W-1:0]     res_score,
    output logic                   busy,
    output logic                   err_len,
    output logic [CNT_W-1:0]       frame_cnt
);
    import bnn_cls_pkg::*;

    localparam logic [CLASS_BIN_W-1:0] LAST_K = CLASS_BIN_W'(NUM_CLASSES - 1);

    cls_state_e             state_q, state_d;
    logic [CLASS_BIN_W-1:0] beat_q, beat_d;
    logic [CLASS_BIN_W-1:0] idx_q, idx_d, step_idx;
    logic [SCORE_W-1:0]     max_q, max_d, step_max;
    logic                   invalid_q, invalid_d;
    logic                   err_q, err_d;
    logic [NUM_CLASSES-1:0] onehot_q, onehot_d;
    logic [CLASS_BIN_W-1:0] class_q, class_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   beat_acc;

    cls_argmax_step #(
        .SCORE_W (SCORE_W),
        .IDX_W   (CLASS_BIN_W)
    ) u_argmax_step (
        .first_i (beat_q == '0),
        .max_i   (max_q),
        .idx_i   (idx_q),
        .score_i (score_data),
        .k_i     (beat_q),
        .max_o   (step_max),
        .idx_o   (step_idx)
    );

    // Handshake flags depend on state only, never on the incoming valid.
    assign score_ready = (state_q == COLLECT);
    assign res_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign beat_acc    = score_valid & score_ready;

    assign res_onehot  = onehot_q;
    assign res_class   = class_q;
    assign res_score   = score_q;
    assign err_len     = err_q;
    assign frame_cnt   = cnt_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        max_d     = max_q;
        invalid_d = invalid_q;
        err_d     = err_q;
        onehot_d  = onehot_q;
        class_d   = class_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    beat_d    = '0;
                    max_d     = '0;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    invalid_d = 1'b0;
                end
            end
            COLLECT: begin
                if (beat_acc) begin
                    max_d  = step_max;
                    idx_d  = step_idx;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_K) begin
                        state_d = ENCODE;
                        if (!score_last) err_d = 1'b1;
                    end else if (score_last) begin
                        state_d   = ENCODE;
                        err_d     = 1'b1;
                        invalid_d = 1'b1;
                    end
                end
            end
            ENCODE: begin
                state_d = HOLD;
                if (invalid_q) begin
                    onehot_d = '0;
                    class_d  = CLASS_INVALID;
                    score_d  = '0;
                end else begin
                    onehot_d = NUM_CLASSES'(idx_to_onehot(idx_q));
                    class_d  = idx_q + 1'b1;
                    score_d  = max_q;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            invalid_q <= 1'b0;
            err_q     <= 1'b0;
            onehot_q  <= '0;
            class_q   <= '0;
            score_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            invalid_q <= invalid_d;
            err_q     <= err_d;
            onehot_q  <= onehot_d;
            class_q   <= class_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cls_result_ctrl.sv
// Bench for cls_result_ctrl: directed frames plus randomized frames scored by a
// behavioural argmax model.
module tb_cls_result_ctrl;

    localparam int NC = 10;
    localparam int SW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          score_valid = 1'b0;
    logic          score_last = 1'b0;
    logic          res_ready = 1'b0;
    logic [SW-1:0] score_data = '0;
    logic          score_ready;
    logic          res_valid;
    logic          busy;
    logic          err_len;
    logic [NC-1:0] res_onehot;
    logic [3:0]    res_class;
    logic [SW-1:0] res_score;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    int sc[NC];
    bit lst[NC];

    int            e_beats;
    bit            e_err;
    logic [NC-1:0] e_oh;
    logic [3:0]    e_cls;
    logic [SW-1:0] e_score;

    cls_result_ctrl #(
        .NUM_CLASSES (NC),
        .SCORE_W     (SW),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score_data  (score_data),
        .score_last  (score_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_onehot  (res_onehot),
        .res_class   (res_class),
        .res_score   (res_score),
        .busy        (busy),
        .err_len     (err_len),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame length = up to the first last flag, capped at NC; winner = first maximum.
    task automatic model();
        int  best;
        bit  found;
        e_beats = NC;
        found   = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (lst[i] && !found) begin
                e_beats = i + 1;
                found   = 1'b1;
            end
        end
        best = 0;
        for (int i = 1; i < e_beats; i++) begin
            if (sc[i] > sc[best]) best = i;
        end
        e_err = !(e_beats == NC && lst[NC-1]);
        if (e_beats < NC) begin
            e_oh    = '0;
            e_cls   = 4'd0;
            e_score = '0;
        end else begin
            e_oh    = NC'(1) << best;
            e_cls   = 4'(best + 1);
            e_score = SW'(sc[best]);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid"},  32'(res_valid),  32'd1);
        check({tag, "_onehot"}, 32'(res_onehot), 32'(e_oh));
        check({tag, "_class"},  32'(res_class),  32'(e_cls));
        check({tag, "_score"},  32'(res_score),  32'(e_score));
        check({tag, "_err"},    32'(err_len),    32'(e_err));
    endtask

    task automatic send_beats(input int nb, input int gap_pct);
        for (int k = 0; k < nb; k++) begin
            int n;
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                score_valid = 1'b0;
                score_data  = SW'($urandom);
                score_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            score_valid = 1'b1;
            score_data  = SW'(sc[k]);
            score_last  = lst[k];
            n = 0;
            while (!score_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("beat_ready", 32'(score_ready), 32'd1);
            @(posedge clk); #1;
            score_valid = 1'b0;
            score_last  = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input int gap_pct, input int hold_cycles,
                             input bit start_in_hold, input bit start_on_hs);
        model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_err_clear"},  32'(err_len), 32'd0);
        send_beats(e_beats, gap_pct);
        check({tag, "_encode_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_encode_busy"},  32'(busy), 32'd1);
        @(posedge clk); #1;
        check_result(tag);
        check({tag, "_cnt_hold"}, 32'(frame_cnt), 32'(exp_cnt));
        for (int h = 0; h < hold_cycles; h++) begin
            res_ready   = 1'b0;
            score_valid = 1'($urandom);
            score_data  = SW'($urandom);
            start       = start_in_hold && (h == hold_cycles / 2);
            @(posedge clk); #1;
            start       = 1'b0;
            score_valid = 1'b0;
            check({tag, "_hold_sready"}, 32'(score_ready), 32'd0);
            check_result({tag, "_hold"});
            check({tag, "_hold_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        end
        res_ready = 1'b1;
        start     = start_on_hs;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        exp_cnt++;
        check({tag, "_post_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_post_busy"},  32'(busy), 32'd0);
        check({tag, "_post_cnt"},   32'(frame_cnt), 32'(exp_cnt));
        check({tag, "_post_class"}, 32'(res_class), 32'(e_cls));
        check({tag, "_post_err"},   32'(err_len), 32'(e_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_sready"}, 32'(score_ready), 32'd0);
        check({tag, "_valid"},  32'(res_valid), 32'd0);
        check({tag, "_err"},    32'(err_len), 32'd0);
        check({tag, "_onehot"}, 32'(res_onehot), 32'd0);
        check({tag, "_class"},  32'(res_class), 32'd0);
        check({tag, "_score"},  32'(res_score), 32'd0);
        check({tag, "_cnt"},    32'(frame_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero("reset");

        sc  = '{5, 9, 3, 40, 40, 7, 1, 0, 2, 39};
        lst = '{default: 1'b0};
        lst[9] = 1'b1;
        run_frame("plan_a", 0, 0, 1'b0, 1'b0);
        check("plan_a_class4", 32'(res_class), 32'd4);

        sc  = '{default: 0};
        run_frame("zeros", 0, 0, 1'b0, 1'b0);

        sc  = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0};
        lst = '{default: 1'b0};
        lst[4] = 1'b1;
        run_frame("short", 0, 1, 1'b0, 1'b0);

        for (int i = 0; i < NC - 1; i++) sc[i] = int'($urandom_range(0, 1022));
        sc[9] = 1023;
        lst   = '{default: 1'b0};
        run_frame("nolast", 20, 0, 1'b0, 1'b0);

        for (int i = 0; i < NC; i++) sc[i] = int'($urandom_range(0, 1023));
        lst[9] = 1'b1;
        run_frame("stall", 40, 20, 1'b1, 1'b0);

        run_frame("hs_start", 10, 2, 1'b0, 1'b1);
        check("hs_start_idle", 32'(busy), 32'd0);

        sc = '{default: 1023};
        run_frame("allmax", 0, 0, 1'b0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            int r;
            for (int i = 0; i < NC; i++) sc[i] = int'((f % 2) ? $urandom_range(0, 1023) : $urandom_range(0, 7));
            lst = '{default: 1'b0};
            r = int'($urandom_range(0, 5));
            if (r == 0) lst[$urandom_range(0, NC - 2)] = 1'b1;
            else if (r != 1) lst[NC-1] = 1'b1;
            run_frame("rand", 30, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        for (int i = 0; i < NC; i++) sc[i] = int'($urandom_range(0, 1023));
        lst = '{default: 1'b0};
        lst[9] = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_beats(5, 0);
        score_valid = 1'b1;
        score_data  = SW'(sc[5]);
        rst_n       = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        score_valid = 1'b0;
        exp_cnt     = 0;
        check_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        check("midreset_no_result", 32'(res_valid), 32'd0);

        sc  = '{5, 9, 3, 40, 40, 7, 1, 0, 2, 39};
        run_frame("after_rst", 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
